// File: rtl/game_tick_gen.sv
// Game-speed timebase: gameplay tick, tick-toggled clock and speed level that
// accelerate during play, plus a free-running idle clock outside play.
module game_tick_gen #(
  parameter int unsigned CNT_W           = 28,
  parameter int unsigned PERIOD_INIT     = 150000,
  parameter int unsigned PERIOD_MIN      = 80000,
  parameter int unsigned PERIOD_STEP     = 10000,
  parameter int unsigned TICKS_PER_LEVEL = 10000,
  parameter int unsigned LVL_W           = 4,
  parameter int unsigned IDLE_DIV_LOG2   = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       game_state,
  input  logic             pause,
  output logic             tick,
  output logic             clk_div,
  output logic [CNT_W-1:0] period,
  output logic [LVL_W-1:0] level,
  output logic             at_max_speed
);

  localparam int unsigned TC_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

  localparam logic [CNT_W-1:0] P_INIT      = CNT_W'(PERIOD_INIT);
  localparam logic [CNT_W-1:0] P_MIN       = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_STEP      = CNT_W'(PERIOD_STEP);
  localparam logic [TC_W-1:0]  TICK_LAST   = TC_W'(TICKS_PER_LEVEL - 1);
  localparam logic [LVL_W-1:0] LVL_MAX     = {LVL_W{1'b1}};
  localparam logic             AT_MAX_INIT = (PERIOD_INIT == PERIOD_MIN);

  localparam logic [1:0] GS_START = 2'd1;
  localparam logic [1:0] GS_END   = 2'd2;

  logic [CNT_W-1:0]         r_cnt;
  logic [TC_W-1:0]          r_tick_cnt;
  logic [CNT_W-1:0]         r_period;
  logic [LVL_W-1:0]         r_level;
  logic                     r_tick;
  logic                     r_clk_div;
  logic                     r_at_max;
  logic [IDLE_DIV_LOG2-1:0] r_idle_cnt;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TC_W-1:0]  w_tick_cnt_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [LVL_W-1:0] w_level_nxt;
  logic             w_tick_nxt;
  logic             w_clk_div_nxt;
  logic             w_at_max_nxt;
  logic [CNT_W-1:0] w_period_dec;
  logic             w_idle_bit;

  assign w_idle_bit = r_idle_cnt[IDLE_DIV_LOG2-1];

  // Period after one speed-up, clamped at the floor without underflow
  assign w_period_dec = ((r_period - P_MIN) >= P_STEP) ? (r_period - P_STEP) : P_MIN;

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_tick_cnt_nxt = r_tick_cnt;
    w_period_nxt   = r_period;
    w_level_nxt    = r_level;
    w_tick_nxt     = 1'b0;
    w_clk_div_nxt  = r_clk_div;
    w_at_max_nxt   = r_at_max;
    case (game_state)
      GS_START: begin
        if (!pause) begin
          if (r_cnt < r_period) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_cnt_nxt     = '0;
            w_tick_nxt    = 1'b1;
            w_clk_div_nxt = ~r_clk_div;
            if (r_tick_cnt == TICK_LAST) begin
              w_tick_cnt_nxt = '0;
              w_period_nxt   = w_period_dec;
              w_at_max_nxt   = (w_period_dec == P_MIN);
              if (r_level != LVL_MAX) w_level_nxt = r_level + LVL_W'(1);
            end else begin
              w_tick_cnt_nxt = r_tick_cnt + TC_W'(1);
            end
          end
        end
      end
      GS_END: begin
        w_clk_div_nxt = w_idle_bit;
      end
      default: begin
        w_cnt_nxt      = '0;
        w_tick_cnt_nxt = '0;
        w_period_nxt   = P_INIT;
        w_level_nxt    = '0;
        w_clk_div_nxt  = w_idle_bit;
        w_at_max_nxt   = AT_MAX_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_tick_cnt <= '0;
      r_period   <= P_INIT;
      r_level    <= '0;
      r_tick     <= 1'b0;
      r_clk_div  <= 1'b1;
      r_at_max   <= AT_MAX_INIT;
      r_idle_cnt <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_period   <= w_period_nxt;
      r_level    <= w_level_nxt;
      r_tick     <= w_tick_nxt;
      r_clk_div  <= w_clk_div_nxt;
      r_at_max   <= w_at_max_nxt;
      r_idle_cnt <= r_idle_cnt + IDLE_DIV_LOG2'(1);
    end
  end

  assign tick         = r_tick;
  assign clk_div      = r_clk_div;
  assign period       = r_period;
  assign level        = r_level;
  assign at_max_speed = r_at_max;

endmodule

// File: doc/game_tick_gen.md
Name: game_tick_gen

Overview:
- Parametrised game-speed timebase. Produces the gameplay tick, a toggle clock and a speed level for the obstacle, scoring and animation logic.
- During play it accelerates: every TICKS_PER_LEVEL ticks the tick period shrinks by PERIOD_STEP, down to a clamped floor.
- Outside play it supplies a slow free-running idle clock for attract and game-over animation.
- Sits between the game FSM (game_state) and all per-frame logic.

Parameters:
- CNT_W, 28: width of the period counter and of the period register.
- PERIOD_INIT, 150000: starting period, in clk cycles minus 1, between ticks.
- PERIOD_MIN, 80000: floor of the period. Constraint: PERIOD_MIN <= PERIOD_INIT < 2^CNT_W.
- PERIOD_STEP, 10000: period decrement per level. Must be >0.
- TICKS_PER_LEVEL, 10000: ticks between speed-ups. Must be >=1.
- LVL_W, 4: width of the level output.
- IDLE_DIV_LOG2, 23: the idle clock is bit IDLE_DIV_LOG2-1 of a free-running counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- game_state  in  2  0=INIT, 1=START, 2=END, 3=RESET.
- pause  in  1  freezes play timing while game_state==START.
- tick  out  1  one-clk pulse per game tick; registered.
- clk_div  out  1  registered. Toggles on each tick in START; otherwise follows the idle clock.
- period  out  CNT_W  current period value.
- level  out  LVL_W  number of speed-ups applied; saturates at 2^LVL_W-1.
- at_max_speed  out  1  high when period==PERIOD_MIN; registered.

Behaviour:
- Reset (rst_n=0, asynchronous): cnt=0, tick_cnt=0, period=PERIOD_INIT, level=0, tick=0, clk_div=1, idle counter=0, at_max_speed=(PERIOD_INIT==PERIOD_MIN).
- tick_cnt width is clog2(TICKS_PER_LEVEL), minimum 1.
- Idle counter increments every clk in all states. It is never cleared except by rst_n.
- START with pause=0:
  - If cnt<period: cnt+1.
  - Else (cnt==period): cnt<=0, tick<=1 for exactly one cycle, clk_div<=~clk_div.
  - Tick spacing is therefore period+1 cycles.
  - On a tick: if tick_cnt==TICKS_PER_LEVEL-1, then tick_cnt<=0 and a speed-up occurs; else tick_cnt+1.
- Speed-up:
  - If period >= PERIOD_MIN+PERIOD_STEP: period-=PERIOD_STEP. Otherwise period<=PERIOD_MIN (clamp; the period never goes below PERIOD_MIN).
  - level+1, saturating. Level increments even when the period is already at the floor.
  - The new period applies from the next counting interval.
- START with pause=1: cnt, tick_cnt, period, level and clk_div hold; tick=0. Releasing pause resumes counting from the held cnt.
- END: cnt, tick_cnt, period and level freeze. clk_div<=idle bit; tick=0.
- INIT or RESET: cnt=0, tick_cnt=0, period=PERIOD_INIT, level=0, clk_div<=idle bit, tick=0.
- Entering START from INIT/RESET: cnt begins at 0, so the first tick occurs PERIOD_INIT+1 cycles after entry.
- Entering START from END: timing resumes from the frozen cnt and period.
- game_state leaving START on the same cycle cnt==period: no tick is issued. The new state's rule applies.
- All outputs are registered. tick and clk_div change on the same edge.
- at_max_speed is updated together with period.

Test Plan:
- Parameters for the bench: PERIOD_INIT=10, PERIOD_MIN=4, PERIOD_STEP=4, TICKS_PER_LEVEL=2, LVL_W=2, IDLE_DIV_LOG2=3, CNT_W=8.
- Reset: assert rst_n=0 mid-run -> immediately tick=0, clk_div=1, period=10, level=0, at_max_speed=0.
- Acceleration and clamp: hold game_state=1 from INIT.
  - First tick 11 cycles after entry, then ticks every 11 cycles, with clk_div toggling on each tick.
  - After the 2nd tick: period=6, level=1, ticks every 7 cycles.
  - After the 4th tick: period=4 (clamp, since 6-4<4), at_max_speed=1, level=2.
  - After the 6th tick: period stays 4, level=3. After the 8th tick: level stays 3 (saturated).
- Pause: pause=1 for 20 cycles when cnt=5 -> no tick, cnt and clk_div held. Release -> next tick exactly period-5+1 cycles later.
- END then START: go to END at cnt=3, period=6 -> period and level held; clk_div toggles every 4 clk with the idle bit. Return to START -> next tick 4 cycles later.
- RESET state: game_state=3 for 1 cycle -> period=10, level=0, cnt=0. Then START -> first tick after 11 cycles.
- Boundary: switch game_state 1->2 on the exact cycle cnt==period -> no tick pulse, and tick_cnt is unchanged.
